// File: rtl/aes_axis_pkg.sv
// Shared types and helpers for the AES stream front end.
// Contents:
//   WORD_S, BLK_S, BYTE_S, WORDS_PER_BLK - widths used by the block builders.
//   word_t, blk_t - ascending-range vectors; bit 0 is the MSB.
//   swap_bytes32  - reverses the four bytes of a stream word.
package aes_axis_pkg;

  localparam int WORD_S        = 32;
  localparam int BLK_S         = 128;
  localparam int BYTE_S        = 8;
  localparam int WORDS_PER_BLK = BLK_S / WORD_S;

  typedef logic [0:WORD_S-1] word_t;
  typedef logic [0:BLK_S-1]  blk_t;

  // Host DMA words are little-endian; the AES core wants kernel byte order.
  function automatic word_t swap_bytes32(input word_t w);
    word_t r;
    for (int b = 0; b < 4; b++) begin
      r[b*BYTE_S +: BYTE_S] = w[(3-b)*BYTE_S +: BYTE_S];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_blk_deserializer_if.sv
// Bundle of the word stream input and the block output of the deserializer.
// Stream side: s_axis_tdata/tvalid/tlast in, s_axis_tready out.
// Block side : blk_o, blk_valid_o, blk_last_o, blk_short_o, blk_cnt_o out,
//              blk_ready_i in.
// slave  - view taken by the deserializer.
// master - view taken by whatever drives the stream and consumes blocks.
interface axis_blk_deserializer_if;
  import aes_axis_pkg::*;

  logic [WORD_S-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  blk_t              blk_o;
  logic              blk_valid_o;
  logic              blk_ready_i;
  logic              blk_last_o;
  logic              blk_short_o;
  logic [15:0]       blk_cnt_o;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, blk_ready_i,
    output s_axis_tready, blk_o, blk_valid_o, blk_last_o, blk_short_o, blk_cnt_o
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, blk_ready_i,
    input  s_axis_tready, blk_o, blk_valid_o, blk_last_o, blk_short_o, blk_cnt_o
  );

endinterface

// File: rtl/axis_word_collector.sv
// Gathers stream words into a partial AES block.
// Ports:
//   aclk, areset - clock, asynchronous active-high reset.
//   accept_i     - a word is taken this cycle.
//   complete_i   - the taken word finishes the block (counter 3 or tlast).
//   word_i       - raw stream word.
//   cnt_o        - index the next word will occupy (0..3).
//   blk_o        - partial block with word_i merged at cnt_o and every
//                  later word forced to zero; valid as the finished block
//                  whenever complete_i is high.
module axis_word_collector
  import aes_axis_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       accept_i,
  input  logic       complete_i,
  input  word_t      word_i,
  output logic [1:0] cnt_o,
  output blk_t       blk_o
);

  logic [1:0] cnt_q, cnt_d;
  blk_t       collect_q, collect_d;
  word_t      placed;
  blk_t       merged;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    placed    = SWAP_BYTES ? swap_bytes32(word_i) : word_i;
    merged    = collect_q;
    merged[int'(cnt_q)*WORD_S +: WORD_S] = placed;
    // Zero padding for a short block: nothing past the current slot survives.
    for (int k = 0; k < WORDS_PER_BLK; k++) begin
      if (k > int'(cnt_q)) merged[k*WORD_S +: WORD_S] = '0;
    end
    cnt_d     = cnt_q;
    collect_d = collect_q;
    if (accept_i) begin
      if (complete_i) begin
        cnt_d     = 2'd0;
        collect_d = '0;
      end else begin
        cnt_d     = cnt_q + 2'd1;
        collect_d = merged;
      end
    end
  end

  // NOTE: the collect register is a plain data register, but it is reset so
  // that a block interrupted by reset can never leak stale words.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q     <= 2'd0;
      collect_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples the values from before the edge.
      cnt_q     <= cnt_d;
      collect_q <= collect_d;
    end
  end

  assign cnt_o = cnt_q;
  assign blk_o = merged;

endmodule

// File: rtl/axis_blk_deserializer.sv
// AXI4-Stream slave turning 32-bit host words into 128-bit AES blocks.
// Ports:
//   aclk   - clock, rising edge.
//   areset - asynchronous active-high reset.
//   bus    - slave view of the stream input / block output bundle.
// Words are packed by axis_word_collector; this level owns the one-block
// output slot, both handshakes and the handed-off block counter.
module axis_blk_deserializer
  import aes_axis_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic                     aclk,
  input  logic                     areset,
  axis_blk_deserializer_if.slave   bus
);

  logic [1:0]  cnt;
  blk_t        merged;
  logic        slot_free, tready, accept, complete, handoff;

  blk_t        blk_q, blk_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        short_q, short_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;

  // The slot counts as free when the consumer drains it this very cycle.
  assign slot_free = !valid_q || bus.blk_ready_i;
  // Non-completing words never stall; a completing word waits for the slot.
  assign tready    = !areset && (slot_free || cnt != 2'd3) &&
                     !(bus.s_axis_tlast && !slot_free);
  assign accept    = bus.s_axis_tvalid && tready;
  assign complete  = accept && (cnt == 2'd3 || bus.s_axis_tlast);
  assign handoff   = valid_q && bus.blk_ready_i;

  axis_word_collector #(
    .SWAP_BYTES (SWAP_BYTES)
  ) u_collector (
    .aclk       (aclk),
    .areset     (areset),
    .accept_i   (accept),
    .complete_i (complete),
    .word_i     (bus.s_axis_tdata),
    .cnt_o      (cnt),
    .blk_o      (merged)
  );

  always_comb begin
    blk_d     = blk_q;
    valid_d   = valid_q;
    last_d    = last_q;
    short_d   = short_q;
    blk_cnt_d = blk_cnt_q + {15'd0, handoff};
    // A new block overrides a same-cycle hand-off so valid stays high.
    if (complete) begin
      blk_d   = merged;
      valid_d = 1'b1;
      last_d  = bus.s_axis_tlast;
      short_d = bus.s_axis_tlast && (cnt != 2'd3);
    end else if (handoff) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      blk_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      short_q   <= 1'b0;
      blk_cnt_q <= 16'd0;
    end else begin
      blk_q     <= blk_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      short_q   <= short_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.blk_o         = blk_q;
  assign bus.blk_valid_o   = valid_q;
  assign bus.blk_last_o    = last_q;
  assign bus.blk_short_o   = short_q;
  assign bus.blk_cnt_o     = blk_cnt_q;

endmodule

// File: tb/tb_axis_blk_deserializer.sv
// Self-checking bench for axis_blk_deserializer: word vectors from a table,
// expected blocks queued on the completing accept and compared on hand-off.
module tb_axis_blk_deserializer;
  import aes_axis_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [31:0] exp_w;   // word as it must appear inside the block
  } vec_t;

  typedef struct {
    logic [127:0] blk;
    logic         last;
    logic         short_b;
  } exp_t;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axis_blk_deserializer_if if_main ();
  axis_blk_deserializer_if if_raw ();

  axis_blk_deserializer #(.SWAP_BYTES(1'b1)) u_dut (
    .aclk (aclk), .areset (areset), .bus (if_main));
  axis_blk_deserializer #(.SWAP_BYTES(1'b0)) u_raw (
    .aclk (aclk), .areset (areset), .bus (if_raw));

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   hs_count = 0;

  logic rand_rdy = 1'b0;
  logic rdy_rand = 1'b0;
  logic rdy_man  = 1'b1;
  assign if_main.blk_ready_i = rand_rdy ? rdy_rand : rdy_man;

  always @(posedge aclk) begin
    #1;
    rdy_rand = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference of the block being collected, in bench terms.
  logic [31:0] mw[4];
  int          mcnt = 0;

  task automatic model_word(input logic [31:0] exp_w, input logic l);
    exp_t e;
    mw[mcnt] = exp_w;
    if (mcnt == 3 || l) begin
      e.blk = '0;
      for (int k = 0; k <= mcnt; k++) e.blk[127-32*k -: 32] = mw[k];
      e.last    = l;
      e.short_b = l && (mcnt < 3);
      sb.push_back(e);
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Starts at posedge+1, ends at posedge+1 right after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic l,
                           input logic [31:0] exp_w, output int waits);
    if_main.s_axis_tvalid = 1'b1;
    if_main.s_axis_tdata  = d;
    if_main.s_axis_tlast  = l;
    waits = 0;
    @(negedge aclk);
    while (!if_main.s_axis_tready && waits < 100) begin
      waits++;
      @(negedge aclk);
    end
    check("accept_wait", {127'd0, if_main.s_axis_tready}, 128'd1);
    model_word(exp_w, l);
    @(posedge aclk);
    #1;
    if_main.s_axis_tvalid = 1'b0;
    if_main.s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge aclk);
      n++;
    end
    check("drain_empty", 128'(sb.size()), 128'd0);
    @(posedge aclk);
    #1;
  endtask

  // Output monitor: hand-off scoreboard plus hold-rule checks.
  logic         stall_prev = 1'b0;
  logic [127:0] held_blk;
  logic         held_last, held_short;

  always @(negedge aclk) begin
    if (areset) begin
      stall_prev = 1'b0;
      hs_count   = 0;
    end else begin
      if (stall_prev) begin
        check("hold_blk",   if_main.blk_o,       held_blk);
        check("hold_last",  {127'd0, if_main.blk_last_o},  {127'd0, held_last});
        check("hold_short", {127'd0, if_main.blk_short_o}, {127'd0, held_short});
      end
      if (if_main.blk_valid_o && if_main.blk_ready_i) begin
        hs_count++;
        if (sb.size() == 0) begin
          check("unexpected_blk", {127'd0, if_main.blk_valid_o}, 128'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("blk_data",  if_main.blk_o, e.blk);
          check("blk_last",  {127'd0, if_main.blk_last_o},  {127'd0, e.last});
          check("blk_short", {127'd0, if_main.blk_short_o}, {127'd0, e.short_b});
        end
      end
      stall_prev = if_main.blk_valid_o && !if_main.blk_ready_i;
      held_blk   = if_main.blk_o;
      held_last  = if_main.blk_last_o;
      held_short = if_main.blk_short_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vtab[18];
    int   w;
    logic [31:0] d;
    logic        l;

    vtab = '{
      '{32'h33221100, 1'b0, 32'h00112233}, '{32'h77665544, 1'b0, 32'h44556677},
      '{32'hBBAA9988, 1'b0, 32'h8899AABB}, '{32'hFFEEDDCC, 1'b1, 32'hCCDDEEFF},
      '{32'h03020100, 1'b0, 32'h00010203}, '{32'h07060504, 1'b0, 32'h04050607},
      '{32'h0B0A0908, 1'b0, 32'h08090A0B}, '{32'h0F0E0D0C, 1'b0, 32'h0C0D0E0F},
      '{32'h13121110, 1'b0, 32'h10111213}, '{32'h17161514, 1'b0, 32'h14151617},
      '{32'h1B1A1918, 1'b0, 32'h18191A1B}, '{32'h1F1E1D1C, 1'b1, 32'h1C1D1E1F},
      '{32'hA0B0C0D0, 1'b0, 32'hD0C0B0A0}, '{32'h11223344, 1'b0, 32'h44332211},
      '{32'hDEADBEEF, 1'b0, 32'hEFBEADDE}, '{32'h01234567, 1'b0, 32'h67452301},
      '{32'hCAFEF00D, 1'b0, 32'h0DF0FECA}, '{32'h89ABCDEF, 1'b1, 32'hEFCDAB89}
    };

    if_main.s_axis_tvalid = 1'b0;
    if_main.s_axis_tdata  = '0;
    if_main.s_axis_tlast  = 1'b0;
    if_raw.s_axis_tvalid  = 1'b0;
    if_raw.s_axis_tdata   = '0;
    if_raw.s_axis_tlast   = 1'b0;
    if_raw.blk_ready_i    = 1'b1;

    // Reset state.
    repeat (2) @(negedge aclk);
    check("rst_tready", {127'd0, if_main.s_axis_tready}, 128'd0);
    check("rst_valid",  {127'd0, if_main.blk_valid_o},   128'd0);
    check("rst_blk",    if_main.blk_o, 128'd0);
    check("rst_flags",  {126'd0, if_main.blk_last_o, if_main.blk_short_o}, 128'd0);
    check("rst_cnt",    128'(if_main.blk_cnt_o), 128'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("tready_after_rst", {127'd0, if_main.s_axis_tready}, 128'd1);
    @(posedge aclk);
    #1;

    // One full block, one-cycle latency, counter increments on hand-off.
    for (int i = 0; i < 4; i++) send_word(vtab[i].data, vtab[i].last, vtab[i].exp_w, w);
    @(negedge aclk);
    check("latency_valid", {127'd0, if_main.blk_valid_o}, 128'd1);
    check("cnt_before_hs", 128'(if_main.blk_cnt_o), 128'd0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("valid_after_hs", {127'd0, if_main.blk_valid_o}, 128'd0);
    check("cnt_after_hs",   128'(if_main.blk_cnt_o), 128'd1);
    @(posedge aclk);
    #1;

    // Eight words back to back: no stall at all.
    for (int i = 4; i < 12; i++) begin
      send_word(vtab[i].data, vtab[i].last, vtab[i].exp_w, w);
      check("b2b_no_stall", 128'(w), 128'd0);
    end
    drain();

    // Six words, short padded second block; tlast on word 1 is not stalled.
    for (int i = 12; i < 18; i++) begin
      send_word(vtab[i].data, vtab[i].last, vtab[i].exp_w, w);
      check("short_no_stall", 128'(w), 128'd0);
    end
    drain();

    // Consumer stalled: block 1 held, block 2 words 0-2 taken, word 3 waits.
    rdy_man = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d = 32'h5000_0000 + 32'(i * 32'h0101_0101);
      send_word(d, 1'b0, bswap(d), w);
      check("stall_accept", 128'(w), 128'd0);
    end
    d = 32'h5A5A_0707;
    if_main.s_axis_tvalid = 1'b1;
    if_main.s_axis_tdata  = d;
    if_main.s_axis_tlast  = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("stall_tready_low", {127'd0, if_main.s_axis_tready}, 128'd0);
      check("stall_valid",      {127'd0, if_main.blk_valid_o},   128'd1);
    end
    @(posedge aclk);
    #1 rdy_man = 1'b1;
    @(negedge aclk);
    check("release_tready", {127'd0, if_main.s_axis_tready}, 128'd1);
    model_word(bswap(d), 1'b1);
    @(posedge aclk);
    #1;
    if_main.s_axis_tvalid = 1'b0;
    if_main.s_axis_tlast  = 1'b0;
    @(negedge aclk);
    check("replace_valid", {127'd0, if_main.blk_valid_o}, 128'd1);
    @(posedge aclk);
    #1;
    drain();

    // SWAP_BYTES=0 instance passes words straight through.
    for (int i = 0; i < 4; i++) begin
      if_raw.s_axis_tvalid = 1'b1;
      if_raw.s_axis_tdata  = 32'h00112233;
      if_raw.s_axis_tlast  = (i == 3);
      @(negedge aclk);
      check("raw_tready", {127'd0, if_raw.s_axis_tready}, 128'd1);
      @(posedge aclk);
      #1;
    end
    if_raw.s_axis_tvalid = 1'b0;
    if_raw.s_axis_tlast  = 1'b0;
    @(negedge aclk);
    check("raw_valid", {127'd0, if_raw.blk_valid_o}, 128'd1);
    check("raw_blk",   if_raw.blk_o, 128'h00112233_00112233_00112233_00112233);
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) send_word(32'h00112233, i == 3, 32'h33221100, w);
    drain();

    // Reset with a held block and a partial block: both discarded.
    rdy_man = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 32'hDEAD_0000 + 32'(i);
      send_word(d, 1'b0, bswap(d), w);
    end
    areset = 1'b1;
    sb.delete();
    mcnt = 0;
    @(negedge aclk);
    check("midrst_tready", {127'd0, if_main.s_axis_tready}, 128'd0);
    check("midrst_valid",  {127'd0, if_main.blk_valid_o},   128'd0);
    check("midrst_blk",    if_main.blk_o, 128'd0);
    check("midrst_cnt",    128'(if_main.blk_cnt_o), 128'd0);
    @(posedge aclk);
    #1;
    areset  = 1'b0;
    rdy_man = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 32'hF0E0_D000 + 32'(i);
      send_word(d, i == 3, bswap(d), w);
    end
    drain();
    check("fresh_cnt", 128'(if_main.blk_cnt_o), 128'd1);

    // Random traffic with a randomly stalling consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
      d = $urandom;
      l = (i == 59) || ($urandom_range(0, 4) == 0);
      send_word(d, l, bswap(d), w);
    end
    rand_rdy = 1'b0;
    drain();
    check("final_cnt", 128'(if_main.blk_cnt_o), 128'(hs_count[15:0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
